// File: rtl/hilo_pkg.sv
// Shared function codes and FSM state encoding for the HI/LO multiply/divide unit.
package hilo_pkg;

  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_DIVU  = 6'd27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
  endfunction

  function automatic logic is_div_fn(input logic [5:0] fn);
    return (fn == FN_DIV) || (fn == FN_DIVU);
  endfunction

  function automatic logic is_signed_fn(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on unsigned magnitudes.
// Purely combinational; the caller owns all state and sequencing.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_sub;

  always_comb begin
    sum     = {1'b0, acc} + (q[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});
    shifted = {acc, q[WIDTH-1]};
    ge      = shifted >= {1'b0, b};
    // when ge holds the difference is below b, so the truncated subtract is exact
    rem_sub = shifted[WIDTH-1:0] - b;
    acc_nxt = '0;
    q_nxt   = '0;
    if (is_div) begin
      if (ge) begin
        acc_nxt = rem_sub;
        q_nxt   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shifted[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = sum[WIDTH:1];
      q_nxt   = {sum[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative signed/unsigned mul/div owning HI/LO; start->done is WIDTH+1 cycles.
// No backpressure: start is dropped while busy or when flush is high.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Signal,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] Output
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               op_div;
  logic               neg_q;
  logic               neg_r;
  logic               b_zero;
  logic [WIDTH-1:0]   a_orig;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  logic [WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]   q_nxt;
  logic               sgn_a;
  logic               sgn_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (op_div),
    .acc     (acc),
    .q       (q),
    .b       (b),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt)
  );

  always_comb begin
    sgn_a    = is_signed_fn(Signal) & dataA[WIDTH-1];
    sgn_b    = is_signed_fn(Signal) & dataB[WIDTH-1];
    mag_a    = sgn_a ? -dataA : dataA;
    mag_b    = sgn_b ? -dataB : dataB;
    prod     = {acc, q};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -q : q;
    rem_fix  = neg_r ? -acc : acc;
  end

  always_comb begin
    Output = '0;
    if (Signal == FN_MFHI)
      Output = hi;
    else if (Signal == FN_MFLO)
      Output = lo;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      b_zero   <= 1'b0;
      a_orig   <= '0;
      acc      <= '0;
      q        <= '0;
      b        <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush && is_muldiv(Signal)) begin
            op_div <= is_div_fn(Signal);
            // both ops run on magnitudes; quotient and product share one sign rule
            neg_q  <= sgn_a ^ sgn_b;
            neg_r  <= sgn_a;
            b_zero <= (dataB == '0);
            a_orig <= dataA;
            acc    <= '0;
            q      <= mag_a;
            b      <= mag_b;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= acc_nxt;
            q   <= q_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1))
              state <= FIX;
          end
        end
        FIX: begin
          if (!flush) begin
            done <= 1'b1;
            if (!op_div) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (b_zero) begin
              hi       <= a_orig;
              lo       <= '1;
              div_zero <= 1'b1;
            end else begin
              hi       <= rem_fix;
              lo       <= quo_fix;
              div_zero <= 1'b0;
            end
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit at WIDTH=32, plus a WIDTH=16 latency/result check.
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Signal;
  logic        start;
  logic        flush;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] Output;

  logic [5:0]  sig16;
  logic        start16;
  logic        flush16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        busy16;
  logic        done16;
  logic        dz16;
  logic [15:0] out16;

  int checks = 0;
  int errors = 0;
  int n;
  int bad;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .Signal   (Signal),
    .start    (start),
    .dataA    (dataA),
    .dataB    (dataB),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .Output   (Output)
  );

  hilo_muldiv_unit #(.WIDTH(16)) dut16 (
    .clk      (clk),
    .reset    (reset),
    .Signal   (sig16),
    .start    (start16),
    .dataA    (a16),
    .dataB    (b16),
    .flush    (flush16),
    .busy     (busy16),
    .done     (done16),
    .div_zero (dz16),
    .Output   (out16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] bb);
    Signal = fn;
    dataA  = a;
    dataB  = bb;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    Signal = FN_MFLO;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!done && cycles < 40);
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    Signal = FN_MFHI;
    #1;
    chk({tag, "_hi"}, 64'(Output), 64'(exp_hi));
    Signal = FN_MFLO;
    #1;
    chk({tag, "_lo"}, 64'(Output), 64'(exp_lo));
  endtask

  initial begin
    reset   = 1'b0;
    Signal  = 6'd0;
    start   = 1'b0;
    flush   = 1'b0;
    dataA   = '0;
    dataB   = '0;
    sig16   = 6'd0;
    start16 = 1'b0;
    flush16 = 1'b0;
    a16     = '0;
    b16     = '0;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    read_hilo("rst", 32'd0, 32'd0);
    reset = 1'b1;
    tick();

    // non-mul/div code on start must not launch anything
    launch(FN_MFHI, 32'd5, 32'd3);
    chk("bad_code_busy", 64'(busy), 64'd0);

    // DIVU 100/7 with full busy/done timing window
    launch(FN_DIVU, 32'd100, 32'd7);
    chk("s1_busy_e0", 64'(busy), 64'd1);
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (busy !== 1'b1 || done !== 1'b0) bad++;
    end
    chk("s1_busy_window", 64'(bad), 64'd0);
    tick();
    chk("s1_done_e33", 64'(done), 64'd1);
    chk("s1_busy_e33", 64'(busy), 64'd0);
    read_hilo("s1", 32'd2, 32'd14);
    tick();
    chk("s1_done_pulse", 64'(done), 64'd0);

    launch(FN_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    chk("s2_lat", 64'(n), 64'd33);
    read_hilo("s2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    launch(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    read_hilo("s3u", 32'hFFFF_FFFE, 32'h0000_0001);

    launch(FN_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done(n);
    read_hilo("s3s", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    launch(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    read_hilo("ovf", 32'd0, 32'h8000_0000);
    chk("ovf_dz", 64'(div_zero), 64'd0);

    launch(FN_DIVU, 32'd1234, 32'd0);
    wait_done(n);
    chk("dz_lat", 64'(n), 64'd33);
    read_hilo("dz", 32'd1234, 32'hFFFF_FFFF);
    chk("dz_flag", 64'(div_zero), 64'd1);

    launch(FN_DIV, 32'hFFFF_FFFB, 32'd0);
    wait_done(n);
    read_hilo("dzs", 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    launch(FN_DIVU, 32'd9, 32'd3);
    wait_done(n);
    read_hilo("s4b", 32'd0, 32'd3);
    chk("s4b_dz_clr", 64'(div_zero), 64'd0);

    // ignored second start and stale reads while busy
    launch(FN_DIVU, 32'd100, 32'd7);
    wait_done(n);
    tick();
    launch(FN_MULTU, 32'd6, 32'd7);
    for (int i = 1; i <= 4; i++) tick();
    Signal = FN_DIVU;
    dataA  = 32'd9;
    dataB  = 32'd3;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    Signal = FN_MFLO;
    #1;
    chk("s5_busy_read", 64'(Output), 64'd14);
    n = 5;
    do begin
      tick();
      n++;
    end while (!done && n < 40);
    chk("s5_lat", 64'(n), 64'd33);
    read_hilo("s5", 32'd0, 32'd42);

    // flush mid-divide
    tick();
    launch(FN_DIVU, 32'd100, 32'd7);
    for (int i = 1; i <= 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_busy", 64'(busy), 64'd0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (done !== 1'b0) bad++;
      tick();
    end
    chk("fl_no_done", 64'(bad), 64'd0);
    read_hilo("fl", 32'd0, 32'd42);
    launch(FN_DIVU, 32'd9, 32'd3);
    wait_done(n);
    read_hilo("fl_after", 32'd0, 32'd3);

    // asynchronous reset mid-divide
    tick();
    launch(FN_DIVU, 32'd100, 32'd7);
    for (int i = 1; i <= 9; i++) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("mr_busy", 64'(busy), 64'd0);
    read_hilo("mr", 32'd0, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // WIDTH=16 instance: DIVU 100/7, done at edge 17
    sig16   = FN_DIVU;
    a16     = 16'd100;
    b16     = 16'd7;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    sig16   = FN_MFLO;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done16 && n < 40);
    chk("w16_lat", 64'(n), 64'd17);
    #1;
    chk("w16_lo", 64'(out16), 64'd14);
    sig16 = FN_MFHI;
    #1;
    chk("w16_hi", 64'(out16), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
